uart_rx_fifo: RTL

//  Downstream drain stage for the UART receiver. Watches the receiver's latched data-ready and error flags,

---
 rtl/uart_rx_fifo.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
// Drain stage behind the UART receiver. It captures each latched word and
// its frame-error flag into a first-word-fall-through FIFO, sends clear
// pulses back to the receiver, and reports level, full, empty and a sticky
// overflow flag to the host.
module uart_rx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    rx_rdy_i,
    input  logic                    rx_err_i,
    input  logic [DATA_WIDTH-1:0]   rx_data_i,
    output logic                    rx_rdy_clr_o,
    output logic                    rx_err_clr_o,
    input  logic                    rd_en_i,
    output logic [DATA_WIDTH-1:0]   rd_data_o,
    output logic                    rd_err_o,
    output logic                    empty_o,
    output logic                    full_o,
    output logic [$clog2(DEPTH):0]  count_o,
    output logic                    overflow_o,
    input  logic                    ovf_clr_i
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        CAP_IDLE,
        CAP_PUSH,
        CAP_CLR,
        CAP_WAIT
    } capState_e;

    capState_e              state_q;
    logic                   rdyClr_q;
    logic                   errClr_q;

    // Each entry holds the frame-error flag above the data word.
    logic [DATA_WIDTH:0]    mem_q [DEPTH];
    logic [AW-1:0]          wrPtr_q, wrPtr_d;
    logic [AW-1:0]          rdPtr_q, rdPtr_d;
    logic [CW-1:0]          count_q, count_d;
    logic                   overflow_q, overflow_d;

    logic                   pushReq;
    logic                   pushEn;
    logic                   popEn;
    logic                   emptyInt;
    logic [DATA_WIDTH:0]    headEntry;

    assign emptyInt  = (count_q == '0);
    assign popEn     = rd_en_i && !emptyInt;
    assign pushReq   = (state_q == CAP_PUSH);
    // A full FIFO still accepts a word when the host frees a slot this cycle.
    assign pushEn    = pushReq && ((count_q < CW'(DEPTH)) || popEn);
    assign headEntry = mem_q[rdPtr_q];

    // Capture FSM: one push per ready assertion, then clear pulses, then wait
    // for the receiver's ready latch to drop so the same word is not pushed twice.
    // The error-clear register doubles as the latched error seen in CAP_PUSH.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= CAP_IDLE;
            rdyClr_q <= 1'b0;
            errClr_q <= 1'b0;
        end else begin
            rdyClr_q <= 1'b0;
            errClr_q <= 1'b0;
            case (state_q)
                CAP_IDLE: begin
                    if (rx_rdy_i) state_q <= CAP_PUSH;
                end
                CAP_PUSH: begin
                    rdyClr_q <= 1'b1;
                    errClr_q <= rx_err_i;
                    state_q  <= CAP_CLR;
                end
                CAP_CLR: begin
                    state_q <= CAP_WAIT;
                end
                CAP_WAIT: begin
                    if (!rx_rdy_i) state_q <= CAP_IDLE;
                end
                default: begin
                    state_q <= CAP_IDLE;
                end
            endcase
        end
    end

    // Next-state logic for pointers, level and the sticky overflow flag.
    always_comb begin
        wrPtr_d    = wrPtr_q;
        rdPtr_d    = rdPtr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (pushEn) wrPtr_d = wrPtr_q + AW'(1);
        if (popEn)  rdPtr_d = rdPtr_q + AW'(1);
        case ({pushEn, popEn})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        // A dropped word wins over a same-cycle clear request.
        if (pushReq && !pushEn) begin
            overflow_d = 1'b1;
        end else if (ovf_clr_i) begin
            overflow_d = 1'b0;
        end
    end

    // Pointer, level and overflow registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage array; contents are meaningless until written, so no reset.
    always_ff @(posedge clk_i) begin
        if (pushEn) mem_q[wrPtr_q] <= {rx_err_i, rx_data_i};
    end

    assign rx_rdy_clr_o = rdyClr_q;
    assign rx_err_clr_o = errClr_q;
    assign empty_o      = emptyInt;
    assign full_o       = (count_q == CW'(DEPTH));
    assign count_o      = count_q;
    assign overflow_o   = overflow_q;
    assign rd_data_o    = emptyInt ? '0 : headEntry[DATA_WIDTH-1:0];
    assign rd_err_o     = emptyInt ? 1'b0 : headEntry[DATA_WIDTH];

endmodule
